dwrr_queue_bank: RTL and testbench

Upstream ingress buffer bank for the DWRR arbiter.
- Holds one FIFO per requestor.
- Drives the arbiter's per-requestor request vector from queue occupancy.
- Pops the granted queue and presents the granted packet, tagged with its requestor index, on a registered output port toward the egress link.

---
 rtl/dwrr_pkg.sv | 22 ++
 rtl/dwrr_queue_bank_if.sv | 31 +++
 rtl/dwrr_queue_bank_sync_fifo.sv | 64 ++++++
 rtl/dwrr_queue_bank.sv | 114 +++++++++++
 tb/tb_dwrr_queue_bank.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/dwrr_pkg.sv
// Shared definitions for the DWRR arbiter and its ingress queue bank.
package dwrr_pkg;

  localparam int NUM_REQS = 4;   // requestors / queues
  localparam int QWID     = 8;   // arbiter quantum/deficit width
  localparam int PSIZE    = 1;   // packet size charged per grant
  localparam int DWID     = 8;   // packet data width
  localparam int DEPTH    = 8;   // entries per ingress queue

  // Bit positions inside the sticky error vector.
  typedef enum logic [1:0] {
    ERR_OVF = 2'd0,
    ERR_UDF = 2'd1,
    ERR_GNT = 2'd2
  } err_bit_e;

  // True when more than one bit of v is set.
  function automatic logic multi_hot(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/dwrr_queue_bank_if.sv
// Ingress/egress signal bundle of the DWRR queue bank.
interface dwrr_queue_bank_if #(
  parameter int NUM_REQS = 4,
  parameter int DWID     = 8,
  parameter int PTRWID   = 3,
  parameter int CNTWID   = 2
);
  logic [NUM_REQS-1:0]            push;
  logic [NUM_REQS*DWID-1:0]       push_data;
  logic [NUM_REQS-1:0]            full;
  logic [NUM_REQS-1:0]            reqs;
  logic [NUM_REQS-1:0]            gnt;
  logic                           blk;
  logic                           out_valid;
  logic [DWID-1:0]                out_data;
  logic [CNTWID-1:0]              out_id;
  logic [NUM_REQS*(PTRWID+1)-1:0] occ;
  logic [2:0]                     err;

  // Queue bank side.
  modport slave (
    input  push, push_data, gnt, blk,
    output full, reqs, out_valid, out_data, out_id, occ, err
  );

  // Producer / arbiter / egress side.
  modport master (
    output push, push_data, gnt, blk,
    input  full, reqs, out_valid, out_data, out_id, occ, err
  );
endinterface

// File: rtl/dwrr_queue_bank_sync_fifo.sv
// Single-clock FIFO with a combinational head and an explicit occupancy count.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DWID   = 8,
  parameter int PTRWID = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DWID-1:0]   wr_data,
  input  logic              rd_en,
  output logic [DWID-1:0]   rd_data,
  output logic              full,
  output logic              empty,
  output logic [PTRWID:0]   count
);

  logic [DWID-1:0]   mem_r [DEPTH];
  logic [PTRWID-1:0] wr_ptr_r;
  logic [PTRWID-1:0] rd_ptr_r;
  logic [PTRWID:0]   count_r;
  logic              rd_ok_s;
  logic              wr_ok_s;

  assign full    = (count_r == (PTRWID+1)'(DEPTH));
  assign empty   = (count_r == {(PTRWID+1){1'b0}});
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    rd_ok_s = rd_en & ~empty;
    wr_ok_s = wr_en & (~full | rd_ok_s);
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks 0..DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTRWID{1'b0}};
      rd_ptr_r <= {PTRWID{1'b0}};
      count_r  <= {(PTRWID+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTRWID'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTRWID'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + (PTRWID+1)'(1);
        2'b01:   count_r <= count_r - (PTRWID+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dwrr_queue_bank.sv
// Per-requestor ingress FIFOs feeding a DWRR arbiter; pops the granted queue
// and presents the packet on a registered egress port.
module dwrr_queue_bank #(
  parameter int NUM_REQS = dwrr_pkg::NUM_REQS,
  parameter int DEPTH    = dwrr_pkg::DEPTH,
  parameter int DWID     = dwrr_pkg::DWID,
  parameter int PTRWID   = $clog2(DEPTH),
  parameter int CNTWID   = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                rst,
  dwrr_queue_bank_if.slave    bus
);
  import dwrr_pkg::*;

  localparam int CW = PTRWID + 1;

  logic [DWID-1:0]     rd_data_s [NUM_REQS];
  logic [CW-1:0]       count_s   [NUM_REQS];
  logic [NUM_REQS-1:0] full_s;
  logic [NUM_REQS-1:0] empty_s;
  logic [NUM_REQS-1:0] pop_s;
  logic                gnt_mh_s;
  logic                gnt_oh_s;
  logic                pop_any_s;
  logic [DWID-1:0]     sel_data_s;
  logic [CNTWID-1:0]   sel_id_s;
  logic [2:0]          err_set_s;

  logic                out_valid_r;
  logic [DWID-1:0]     out_data_r;
  logic [CNTWID-1:0]   out_id_r;
  logic [2:0]          err_r;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_q
    sync_fifo #(
      .DEPTH  (DEPTH),
      .DWID   (DWID),
      .PTRWID (PTRWID)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.push[gi]),
      .wr_data (bus.push_data[gi*DWID +: DWID]),
      .rd_en   (pop_s[gi]),
      .rd_data (rd_data_s[gi]),
      .full    (full_s[gi]),
      .empty   (empty_s[gi]),
      .count   (count_s[gi])
    );
    assign bus.occ[gi*CW +: CW] = count_s[gi];
  end

  // reqs/full come straight from FIFO count registers, never from push/gnt.
  assign bus.full      = full_s;
  assign bus.reqs      = ~empty_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_id    = out_id_r;
  assign bus.err       = err_r;

  // Pop decode: only a one-hot grant on a non-empty queue while not stalled pops.
  always_comb begin
    gnt_mh_s  = multi_hot(32'(bus.gnt));
    gnt_oh_s  = (|bus.gnt) & ~gnt_mh_s;
    pop_s     = bus.gnt & ~empty_s & {NUM_REQS{gnt_oh_s & ~bus.blk}};
    pop_any_s = |pop_s;
  end

  // Select the head and index of the popped queue (at most one bit of pop_s set).
  always_comb begin
    sel_data_s = {DWID{1'b0}};
    sel_id_s   = {CNTWID{1'b0}};
    for (int i = 0; i < NUM_REQS; i++) begin
      sel_data_s = sel_data_s | (pop_s[i] ? rd_data_s[i] : {DWID{1'b0}});
      sel_id_s   = sel_id_s | (pop_s[i] ? CNTWID'(i) : {CNTWID{1'b0}});
    end
  end

  // Error events this cycle: dropped push, grant to empty queue, multi-hot grant.
  always_comb begin
    err_set_s          = 3'b000;
    err_set_s[ERR_OVF] = |(bus.push & full_s & ~pop_s);
    err_set_s[ERR_UDF] = |(bus.gnt & empty_s);
    err_set_s[ERR_GNT] = gnt_mh_s;
  end

  // Egress registers: load on pop, clear valid on idle, hold on stall or multi-hot grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DWID{1'b0}};
      out_id_r    <= {CNTWID{1'b0}};
    end else if (pop_any_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_id_r    <= sel_id_s;
    end else if (!bus.blk && !gnt_mh_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 3'b000;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

endmodule

// File: tb/tb_dwrr_queue_bank.sv
// Directed bench for dwrr_queue_bank: per-queue reference FIFOs feed an
// expected-output scoreboard that is compared when the egress port fires.
module tb_dwrr_queue_bank;
  localparam int NR = 4;
  localparam int DP = 8;
  localparam int DW = 8;
  localparam int PW = 3;
  localparam int CW = 2;

  logic clk;
  logic rst;

  dwrr_queue_bank_if #(.NUM_REQS(NR), .DWID(DW), .PTRWID(PW), .CNTWID(CW)) bus ();

  dwrr_queue_bank #(.NUM_REQS(NR), .DEPTH(DP), .DWID(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [NR][$];   // reference contents per queue
  logic [9:0] sb [$];       // expected {id, data} on egress

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] occ_exp();
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < NR; i++) r[i*4 +: 4] = 4'(mq[i].size());
    return r;
  endfunction

  function automatic logic [3:0] reqs_exp();
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < NR; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NR; i++) mq[i].delete();
    sb.delete();
  endtask

  // One clock cycle of stimulus; exp_pop says the model expects queue idx to pop.
  task automatic cyc(input logic [3:0] pv, input logic [31:0] pd, input logic [3:0] g,
                     input logic b, input logic exp_pop, input int idx);
    logic [9:0] e;
    bus.push      = pv;
    bus.push_data = pd;
    bus.gnt       = g;
    bus.blk       = b;
    if (exp_pop) sb.push_back({idx[1:0], mq[idx].pop_front()});
    for (int i = 0; i < NR; i++)
      if (pv[i] && mq[i].size() < DP) mq[i].push_back(pd[i*8 +: 8]);
    @(posedge clk);
    #1;
    bus.push = 4'b0000;
    bus.gnt  = 4'b0000;
    bus.blk  = 1'b0;
    if (exp_pop) begin
      e = sb.pop_front();
      chk("pop_valid", 32'(bus.out_valid), 32'd1);
      chk("pop_data",  32'(bus.out_data),  32'(e[7:0]));
      chk("pop_id",    32'(bus.out_id),    32'(e[9:8]));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reqs"},  32'(bus.reqs),      32'd0);
    chk({tag, "_full"},  32'(bus.full),      32'd0);
    chk({tag, "_occ"},   32'(bus.occ),       32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_id"},    32'(bus.out_id),    32'd0);
    chk({tag, "_err"},   32'(bus.err),       32'd0);
  endtask

  initial begin
    rst           = 1'b0;
    bus.push      = 4'b0000;
    bus.push_data = 32'h0000_0000;
    bus.gnt       = 4'b0000;
    bus.blk       = 1'b0;
    clear_model();
    #12;
    chk_all_zero("reset");
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: two packets through queue 2
    cyc(4'b0100, 32'h00A1_0000, 4'b0000, 1'b0, 1'b0, 0);
    cyc(4'b0100, 32'h00A2_0000, 4'b0000, 1'b0, 1'b0, 0);
    chk("t1_reqs", 32'(bus.reqs), 32'h4);
    chk("t1_occ2", 32'(bus.occ[8 +: 4]), 32'd2);
    cyc(4'b0000, 32'h0, 4'b0100, 1'b0, 1'b1, 2);
    cyc(4'b0000, 32'h0, 4'b0100, 1'b0, 1'b1, 2);
    chk("t1_reqs_after", 32'(bus.reqs), 32'h0);

    // 2: fill queue 0, overflow, then push+pop while full
    for (int k = 0; k < DP; k++) cyc(4'b0001, 32'(8'h10 + k), 4'b0000, 1'b0, 1'b0, 0);
    chk("t2_full", 32'(bus.full), 32'h1);
    cyc(4'b0001, 32'h99, 4'b0000, 1'b0, 1'b0, 0);
    chk("t2_ovf_err", 32'(bus.err), 32'h1);
    chk("t2_ovf_occ", 32'(bus.occ), 32'(occ_exp()));
    cyc(4'b0001, 32'h77, 4'b0001, 1'b0, 1'b1, 0);
    chk("t2_pp_occ",  32'(bus.occ[3:0]), 32'd8);
    chk("t2_pp_full", 32'(bus.full), 32'h1);
    chk("t2_pp_err",  32'(bus.err), 32'h1);

    // 3: grant to empty queue, then multi-hot grant
    cyc(4'b0000, 32'h0, 4'b0010, 1'b0, 1'b0, 0);
    chk("t3_udf_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_udf_err",   32'(bus.err), 32'h3);
    cyc(4'b0010, 32'h0000_3100, 4'b0000, 1'b0, 1'b0, 0);
    cyc(4'b0000, 32'h0, 4'b0011, 1'b0, 1'b0, 0);
    chk("t3_mh_err",   32'(bus.err), 32'h7);
    chk("t3_mh_occ",   32'(bus.occ), 32'(occ_exp()));
    chk("t3_mh_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < DP; k++) cyc(4'b0000, 32'h0, 4'b0001, 1'b0, 1'b1, 0);
    cyc(4'b0000, 32'h0, 4'b0010, 1'b0, 1'b1, 1);
    chk("t3_drained_reqs", 32'(bus.reqs), 32'h0);

    // 4: stall with queue 3 granted, then release
    cyc(4'b1000, 32'h5500_0000, 4'b0000, 1'b0, 1'b0, 0);
    cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0000, 32'h0, 4'b1000, 1'b1, 1'b0, 0);
      chk("t4_blk_occ3",  32'(bus.occ[12 +: 4]), 32'd1);
      chk("t4_blk_valid", 32'(bus.out_valid), 32'd0);
    end
    cyc(4'b0000, 32'h0, 4'b1000, 1'b0, 1'b1, 3);
    for (int k = 0; k < 2; k++) begin
      cyc(4'b0000, 32'h0, 4'b0001, 1'b1, 1'b0, 0);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_data",  32'(bus.out_data), 32'h55);
      chk("t4_hold_id",    32'(bus.out_id), 32'd3);
    end

    // clean restart so the streaming test can require err==0
    #2 rst = 1'b0;
    clear_model();
    #4 rst = 1'b1;

    // 5: 20 packets through queue 1 with interleaved pops (pointer wraps twice)
    cyc(4'b0010, 32'h0000_8000, 4'b0000, 1'b0, 1'b0, 0);
    for (int k = 1; k < 20; k++)
      cyc(4'b0010, {16'h0000, 8'(8'h80 + k), 8'h00}, 4'b0010, 1'b0, 1'b1, 1);
    cyc(4'b0000, 32'h0, 4'b0010, 1'b0, 1'b1, 1);
    chk("t5_err",  32'(bus.err), 32'h0);
    chk("t5_reqs", 32'(bus.reqs), 32'h0);

    // 6: asynchronous reset mid-stream
    cyc(4'b0101, 32'h00D1_00D0, 4'b0000, 1'b0, 1'b0, 0);
    cyc(4'b0100, 32'h00D2_0000, 4'b1000, 1'b0, 1'b0, 0);
    cyc(4'b0000, 32'h0, 4'b0100, 1'b0, 1'b1, 2);
    chk("t6_pre_reqs", 32'(bus.reqs), 32'(reqs_exp()));
    chk("t6_pre_err",  32'(bus.err), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("t6_async");
    clear_model();
    #2 rst = 1'b1;
    #1;
    chk("t6_rel_reqs", 32'(bus.reqs), 32'h0);
    cyc(4'b0100, 32'h00E1_0000, 4'b0000, 1'b0, 1'b0, 0);
    cyc(4'b0100, 32'h00E2_0000, 4'b0000, 1'b0, 1'b0, 0);
    cyc(4'b0000, 32'h0, 4'b0100, 1'b0, 1'b1, 2);
    chk("t6_occ", 32'(bus.occ), 32'(occ_exp()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
